// File: rtl/vec_lut_pkg.sv
// Shared types and elaboration helpers for the vector LUT unit.
package vec_lut_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Bit offset of a lane within a flat vector.
    function automatic int lane_lo(input int lane, input int elem_w);
        return lane * elem_w;
    endfunction

    function automatic bit lut_params_ok(input int lanes, input int lookups);
        return (lookups > 0) && (lanes >= lookups) && (lanes % lookups == 0);
    endfunction

endpackage

// File: rtl/vec_lut_if.sv
// Config, input and output handshakes of the vector LUT unit.
interface vec_lut_if #(
    parameter int LANES  = 16,
    parameter int ELEM_W = 8
);
    localparam int VEC_W = LANES * ELEM_W;

    logic              cfg_we;
    logic [ELEM_W-1:0] cfg_addr;
    logic [ELEM_W-1:0] cfg_data;
    logic              cfg_ready;
    logic              in_valid;
    logic              in_ready;
    logic [VEC_W-1:0]  in_vec;
    logic [LANES-1:0]  in_mask;
    logic              out_valid;
    logic              out_ready;
    logic [VEC_W-1:0]  out_vec;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_vec, in_mask, out_ready,
        input  cfg_ready, in_ready, out_valid, out_vec
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_vec, in_mask, out_ready,
        output cfg_ready, in_ready, out_valid, out_vec
    );

endinterface

// File: rtl/vec_lut_table.sv
// 2**ELEM_W x ELEM_W substitution table: one sync write port, LOOKUPS async read ports.
module vec_lut_table #(
    parameter int ELEM_W  = 8,
    parameter int LOOKUPS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [ELEM_W-1:0]                waddr,
    input  logic [ELEM_W-1:0]                wdata,
    input  logic [LOOKUPS-1:0][ELEM_W-1:0]   raddr,
    output logic [LOOKUPS-1:0][ELEM_W-1:0]   rdata
);
    localparam int DEPTH = 2 ** ELEM_W;

    logic [DEPTH-1:0][ELEM_W-1:0] mem;

    // Reset loads the identity map so an unconfigured table passes data through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ELEM_W'(i);
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < LOOKUPS; k++) begin : g_rd
        assign rdata[k] = mem[raddr[k]];
    end

endmodule

// File: rtl/vec_lut_unit.sv
// Multi-cycle vector element substitution: LOOKUPS lanes per cycle through a writable table.
module vec_lut_unit
    import vec_lut_pkg::*;
#(
    parameter int LANES   = 16,
    parameter int ELEM_W  = 8,
    parameter int LOOKUPS = 4
) (
    input  logic   clk,
    input  logic   rst,
    vec_lut_if.slave bus,
    output logic   busy
);
    localparam int NCHUNK = LANES / LOOKUPS;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!lut_params_ok(LANES, LOOKUPS)) begin : g_bad_params
        $error("vec_lut_unit: LOOKUPS must divide LANES");
    end

    typedef logic [NCHUNK-1:0][LOOKUPS-1:0][ELEM_W-1:0] vec_t;

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    vec_t src_q, out_q;
    logic [NCHUNK-1:0][LOOKUPS-1:0] mask_q;
    logic [LOOKUPS-1:0][ELEM_W-1:0] rd_addr, rd_data, chunk_nxt;
    logic accept, tbl_we, last;

    // A pending table write blocks input so the write lands before the next vector.
    assign accept = (state == IDLE) && bus.in_valid && !bus.cfg_we;
    assign tbl_we = (state == IDLE) && bus.cfg_we;
    assign last   = (cnt == CNT_W'(NCHUNK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.cfg_ready = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                busy          = 1'b0;
                bus.cfg_ready = 1'b1;
                bus.in_ready  = !bus.cfg_we;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_addr = src_q[cnt];

    for (genvar k = 0; k < LOOKUPS; k++) begin : g_lane
        assign chunk_nxt[k] = mask_q[cnt][k] ? rd_data[k] : rd_addr[k];
    end

    vec_lut_table #(.ELEM_W(ELEM_W), .LOOKUPS(LOOKUPS)) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (tbl_we),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            src_q  <= '0;
            out_q  <= '0;
            mask_q <= '0;
        end else if (accept) begin
            src_q  <= vec_t'(bus.in_vec);
            out_q  <= vec_t'(bus.in_vec);
            mask_q <= bus.in_mask;
            cnt    <= '0;
        end else if (state == RUN) begin
            out_q[cnt] <= chunk_nxt;
            cnt        <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    assign bus.out_vec = out_q;

endmodule

// File: tb/tb_vec_lut_unit.sv
// Scoreboard bench for vec_lut_unit: directed scenarios plus randomized traffic.
module tb_vec_lut_unit;
    import vec_lut_pkg::*;

    localparam int LANES = 16, ELEM_W = 8, LOOKUPS = 4;
    localparam int VEC_W = LANES * ELEM_W;
    localparam int NCHUNK = LANES / LOOKUPS;

    logic clk = 0, rst = 1, busy;
    int   errors = 0, checks = 0, cyc = 0;
    logic rand_rdy = 0;

    logic [ELEM_W-1:0] tbl [256];
    logic [VEC_W-1:0]  exp_q [$];
    int                hs_q  [$];

    vec_lut_if #(.LANES(LANES), .ELEM_W(ELEM_W)) ifc ();

    vec_lut_unit #(.LANES(LANES), .ELEM_W(ELEM_W), .LOOKUPS(LOOKUPS)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifc.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void tbl_identity();
        for (int i = 0; i < 256; i++) tbl[i] = ELEM_W'(i);
    endfunction

    // Reference: each lane independently substituted or passed through.
    function automatic logic [VEC_W-1:0] model(input logic [VEC_W-1:0] v, input logic [LANES-1:0] m);
        logic [VEC_W-1:0] r;
        logic [ELEM_W-1:0] b;
        r = v;
        for (int i = 0; i < LANES; i++) begin
            b = v[lane_lo(i, ELEM_W) +: ELEM_W];
            if (m[i]) r[lane_lo(i, ELEM_W) +: ELEM_W] = tbl[b];
        end
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] splat(input logic [ELEM_W-1:0] b);
        return {LANES{b}};
    endfunction

    task automatic send_cfg(input logic [7:0] a, input logic [7:0] d);
        bit ok = 0;
        ifc.cfg_we = 1; ifc.cfg_addr = a; ifc.cfg_data = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ifc.cfg_ready) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL cfg_timeout actual=0 required=1"); end
        @(posedge clk); #1;
        ifc.cfg_we = 0;
        if (ok) tbl[a] = d;
    endtask

    task automatic send_vec(input logic [VEC_W-1:0] v, input logic [LANES-1:0] m);
        bit ok = 0;
        ifc.in_valid = 1; ifc.in_vec = v; ifc.in_mask = m;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ifc.in_ready) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL in_timeout actual=0 required=1"); end
        else begin
            exp_q.push_back(model(v, m));
            hs_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        ifc.in_valid = 0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        chk("wait_idle", VEC_W'(exp_q.size()), '0);
        @(posedge clk); #1;
    endtask

    // Monitor: latency on each out_valid rise, data on each output handshake.
    bit prev_v = 0;
    always @(negedge clk) begin
        if (rst) prev_v = 0;
        else begin
            if (ifc.out_valid && !prev_v) begin
                if (hs_q.size() > 0) chk("latency", VEC_W'(cyc - hs_q.pop_front()), VEC_W'(NCHUNK));
                else begin errors++; checks++; $display("FAIL unexpected_valid actual=1 required=0"); end
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() > 0) chk("out_vec", ifc.out_vec, exp_q.pop_front());
                else begin errors++; checks++; $display("FAIL unexpected_output actual=%h", ifc.out_vec); end
            end
            prev_v = ifc.out_valid;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) ifc.out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [VEC_W-1:0] v, held;
        logic [LANES-1:0] m;
        ifc.cfg_we = 0; ifc.cfg_addr = 0; ifc.cfg_data = 0;
        ifc.in_valid = 0; ifc.in_vec = 0; ifc.in_mask = 0; ifc.out_ready = 1;
        tbl_identity();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", VEC_W'(ifc.out_valid), '0);
        chk("rst_out_vec",   ifc.out_vec, '0);
        chk("rst_busy",      VEC_W'(busy), '0);
        chk("rst_cfg_ready", VEC_W'(ifc.cfg_ready), VEC_W'(1));
        rst = 0;
        @(posedge clk); #1;

        // 1: identity table
        send_vec(128'h000102030405060708090A0B0C0D0E0F, 16'hFFFF);
        wait_idle();
        // 2, 3: single programmed entry, full and partial mask
        send_cfg(8'hAC, 8'h99);
        send_vec(splat(8'hAC), 16'hFFFF);
        wait_idle();
        send_vec(splat(8'hAC), 16'h00FF);
        wait_idle();
        chk("mask_model_ref", model(splat(8'hAC), 16'h00FF), {{8{8'hAC}}, {8{8'h99}}});

        // 4: back-pressure in DONE
        ifc.out_ready = 0;
        send_vec(128'h00AC11AC22AC33AC44AC55AC66AC77AC, 16'hA5A5);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ifc.out_valid) break;
        end
        held = ifc.out_vec;
        chk("stall_valid", VEC_W'(ifc.out_valid), VEC_W'(1));
        ifc.cfg_we = 1; ifc.cfg_addr = 8'h00; ifc.cfg_data = 8'hEE;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("stall_vec", ifc.out_vec, held);
            chk("stall_in_ready", VEC_W'(ifc.in_ready), '0);
            chk("stall_cfg_ready", VEC_W'(ifc.cfg_ready), '0);
        end
        ifc.cfg_we = 0;
        @(posedge clk); #1;
        ifc.out_ready = 1;
        @(posedge clk); #1;
        chk("release_busy", VEC_W'(busy), '0);
        chk("release_valid", VEC_W'(ifc.out_valid), '0);

        // 5: write and input in the same IDLE cycle
        ifc.cfg_we = 1; ifc.cfg_addr = 8'h10; ifc.cfg_data = 8'h55;
        ifc.in_valid = 1; ifc.in_vec = splat(8'h10); ifc.in_mask = 16'hFFFF;
        @(negedge clk);
        chk("pri_in_ready", VEC_W'(ifc.in_ready), '0);
        chk("pri_cfg_ready", VEC_W'(ifc.cfg_ready), VEC_W'(1));
        @(posedge clk); #1;
        ifc.cfg_we = 0;
        tbl[8'h10] = 8'h55;
        send_vec(splat(8'h10), 16'hFFFF);
        wait_idle();

        // 6: reset in the second RUN cycle
        send_vec(splat(8'hAC), 16'hFFFF);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("midrst_valid", VEC_W'(ifc.out_valid), '0);
        chk("midrst_vec", ifc.out_vec, '0);
        chk("midrst_busy", VEC_W'(busy), '0);
        exp_q.delete(); hs_q.delete();
        tbl_identity();
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        send_vec(splat(8'hAC), 16'hFFFF);
        wait_idle();
        send_vec(splat(8'h10), 16'h0000);
        wait_idle();

        // Randomized traffic with random back-pressure
        rand_rdy = 1;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int w = 0; w < int'($urandom_range(1, 3)); w++)
                    send_cfg(8'($urandom_range(0, 15)), 8'($urandom));
            end
            for (int i = 0; i < LANES; i++)
                v[lane_lo(i, ELEM_W) +: ELEM_W] = ($urandom_range(0, 1) == 1) ?
                    8'($urandom_range(0, 15)) : 8'($urandom);
            m = 16'($urandom);
            send_vec(v, m);
        end
        rand_rdy = 0;
        ifc.out_ready = 1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
